// File: rtl/gearbox_pkg.sv
// Shared types for the gearbox input path: the beat carried per cycle and the arbiter state encoding.
package gearbox_pkg;

    localparam int N_BYTES = 10;
    localparam int NB      = N_BYTES * 8;

    typedef struct packed {
        logic [NB-1:0]      data;
        logic [N_BYTES-1:0] keep;
        logic               last;
    } beat_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Empty non-last beats carry nothing for the gearbox; an empty last still marks the packet end.
    function automatic logic beat_is_fwd(input beat_t b);
        return (|b.keep) || b.last;
    endfunction

endpackage

// File: rtl/axis_out_stage.sv
// One-entry registered valid/ready slice carrying a beat plus its source id.
// The caller only asserts load_i when the slot is empty or draining this cycle.
module axis_out_stage
    import gearbox_pkg::*;
#(
    parameter int IDW = 2
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           load_i,
    input  beat_t          beat_i,
    input  logic [IDW-1:0] tid_i,
    input  logic           ready_i,
    output logic           valid_o,
    output beat_t          beat_o,
    output logic [IDW-1:0] tid_o
);

    logic           valid_q;
    beat_t          beat_q;
    logic [IDW-1:0] tid_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
            tid_q   <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            beat_q  <= beat_i;
            tid_q   <= tid_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign beat_o  = beat_q;
    assign tid_o   = tid_q;

endmodule

// File: rtl/gearbox_stream_arbiter.sv
// Packet-level round-robin arbiter feeding one gearbox_packing input from K AXI-Stream sources.
//   state | meaning
//   IDLE  | no packet granted; pick next requester from rr_ptr, s_tready all low
//   BURST | grant locked to one source until its tlast beat is accepted
module gearbox_stream_arbiter
    import gearbox_pkg::*;
#(
    parameter  int K   = 3,
    parameter  int n   = N_BYTES,
    localparam int NB  = n * 8,
    localparam int IDW = $clog2(K)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [K*NB-1:0]   s_tdata,
    input  logic [K*n-1:0]    s_tkeep,
    input  logic [K-1:0]      s_tlast,
    input  logic [K-1:0]      s_tvalid,
    output logic [K-1:0]      s_tready,
    output logic [NB-1:0]     m_tdata,
    output logic [n-1:0]      m_tkeep,
    output logic              m_tlast,
    output logic [IDW-1:0]    m_tid,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              busy
);

    logic [1:0]     rst_sync_q;
    logic           rst_n_int;
    arb_state_t     state_q;
    logic [IDW-1:0] grant_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    logic [IDW-1:0] pick;
    logic           busy_q;
    int             rr_idx;
    beat_t          sel_beat;
    beat_t          out_beat;
    logic           slot_free;
    logic           accept;
    logic           load;

    // Assert asynchronously, release after two clean edges.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    // Descending scan so the smallest rotation offset from rr_ptr wins.
    always_comb begin
        pick   = '0;
        rr_idx = 0;
        for (int j = K - 1; j >= 0; j--) begin
            rr_idx = (int'(rr_ptr_q) + j) % K;
            if (s_tvalid[rr_idx]) pick = IDW'(rr_idx);
        end
    end

    always_comb begin
        sel_beat.data = s_tdata[int'(grant_q)*NB +: NB];
        sel_beat.keep = s_tkeep[int'(grant_q)*n +: n];
        sel_beat.last = s_tlast[grant_q];
    end

    assign slot_free = !m_tvalid || m_tready;
    assign accept    = (state_q == BURST) && s_tvalid[grant_q] && slot_free;
    assign load      = accept && beat_is_fwd(sel_beat);
    assign rr_ptr_d  = (int'(grant_q) == K - 1) ? '0 : grant_q + 1'b1;

    always_comb begin
        s_tready = '0;
        if (state_q == BURST) s_tready[grant_q] = slot_free;
    end

    always_ff @(posedge aclk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|s_tvalid) begin
                        grant_q <= pick;
                        state_q <= BURST;
                        busy_q  <= 1'b1;
                    end
                end
                BURST: begin
                    if (accept && sel_beat.last) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    axis_out_stage #(
        .IDW (IDW)
    ) u_out (
        .clk_i   (aclk),
        .rst_n_i (rst_n_int),
        .load_i  (load),
        .beat_i  (sel_beat),
        .tid_i   (grant_q),
        .ready_i (m_tready),
        .valid_o (m_tvalid),
        .beat_o  (out_beat),
        .tid_o   (m_tid)
    );

    assign m_tdata = out_beat.data;
    assign m_tkeep = out_beat.keep;
    assign m_tlast = out_beat.last;
    assign busy    = busy_q;

endmodule

// File: tb/tb_gearbox_stream_arbiter.sv
// Directed bench for gearbox_stream_arbiter: per-source beat queues drive the inputs,
// forwarded beats are collected and compared against hand-built expected lists.
module tb_gearbox_stream_arbiter;

    localparam int K  = 3;
    localparam int N  = 10;
    localparam int NB = 80;

    typedef struct packed {
        logic [NB-1:0] data;
        logic [N-1:0]  keep;
        logic          last;
        logic [1:0]    src;
        logic [7:0]    gap;
    } src_beat_t;

    typedef struct packed {
        logic [NB-1:0] data;
        logic [N-1:0]  keep;
        logic          last;
        logic [1:0]    tid;
    } out_beat_t;

    logic            aclk     = 1'b0;
    logic            aresetn  = 1'b0;
    logic [K*NB-1:0] s_tdata  = '0;
    logic [K*N-1:0]  s_tkeep  = '0;
    logic [K-1:0]    s_tlast  = '0;
    logic [K-1:0]    s_tvalid = '0;
    logic [K-1:0]    s_tready;
    logic [NB-1:0]   m_tdata;
    logic [N-1:0]    m_tkeep;
    logic            m_tlast;
    logic [1:0]      m_tid;
    logic            m_tvalid;
    logic            m_tready = 1'b1;
    logic            busy;

    src_beat_t pend[$];
    out_beat_t got_q[$];
    logic [K-1:0] acc = '0;
    logic [K-1:0] loaded = '0;
    int acc_cnt[K];
    int gapc[K];
    int drv_idx;
    int errors = 0;
    int checks = 0;

    gearbox_stream_arbiter #(.K(K), .n(N)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .busy     (busy)
    );

    always #5 aclk = ~aclk;

    function automatic int find_src(input int s);
        for (int k = 0; k < pend.size(); k++)
            if (int'(pend[k].src) == s) return k;
        return -1;
    endfunction

    function automatic logic [NB-1:0] mk(input int s, input int b);
        logic [7:0] v;
        v = 8'(16 * s + b + 1);
        return {10{v}};
    endfunction

    task automatic push(input int s, input logic [NB-1:0] d, input logic [N-1:0] kp,
                        input logic l, input int g);
        src_beat_t e;
        e.data = d; e.keep = kp; e.last = l; e.src = 2'(s); e.gap = 8'(g);
        pend.push_back(e);
    endtask

    function automatic out_beat_t ob(input logic [NB-1:0] d, input logic [N-1:0] kp,
                                     input logic l, input int t);
        out_beat_t e;
        e.data = d; e.keep = kp; e.last = l; e.tid = 2'(t);
        return e;
    endfunction

    // Observation half a cycle before the edge at which the handshakes complete.
    always @(negedge aclk) begin
        out_beat_t e;
        acc = s_tvalid & s_tready;
        for (int i = 0; i < K; i++) if (acc[i]) acc_cnt[i]++;
        if (aresetn && m_tvalid && m_tready) begin
            e.data = m_tdata; e.keep = m_tkeep; e.last = m_tlast; e.tid = m_tid;
            got_q.push_back(e);
        end
    end

    always @(posedge aclk) begin
        #1;
        for (int i = 0; i < K; i++) begin
            if (acc[i]) begin
                drv_idx = find_src(i);
                if (drv_idx >= 0) pend.delete(drv_idx);
                loaded[i] = 1'b0;
            end
            drv_idx = find_src(i);
            if (drv_idx < 0) begin
                s_tvalid[i] = 1'b0;
                loaded[i]   = 1'b0;
            end else begin
                if (!loaded[i]) begin
                    gapc[i]   = int'(pend[drv_idx].gap);
                    loaded[i] = 1'b1;
                end
                if (gapc[i] > 0) begin
                    gapc[i]--;
                    s_tvalid[i] = 1'b0;
                end else begin
                    s_tvalid[i]          = 1'b1;
                    s_tdata[i*NB +: NB]  = pend[drv_idx].data;
                    s_tkeep[i*N +: N]    = pend[drv_idx].keep;
                    s_tlast[i]           = pend[drv_idx].last;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        got_q.delete();
        for (int i = 0; i < K; i++) acc_cnt[i] = 0;
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        pend.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        repeat (5) @(negedge aclk);
        #1;
        clear_obs();
    endtask

    task automatic wait_got(input int cnt, input string name);
        for (int c = 0; c < 100 && got_q.size() < cnt; c++) begin
            @(negedge aclk);
            #1;
        end
        checks++;
        if (got_q.size() < cnt) begin
            errors++;
            $display("FAIL %s timeout: got %0d beats, required %0d", name, got_q.size(), cnt);
        end
    endtask

    task automatic cmp_got(input out_beat_t exp[$], input string name);
        checks++;
        if (got_q.size() !== exp.size()) begin
            errors++;
            $display("FAIL %s count: got %0d required %0d", name, got_q.size(), exp.size());
        end
        for (int k = 0; k < exp.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp[k]) begin
                errors++;
                $display("FAIL %s beat %0d: got %h required %h", name, k, got_q[k], exp[k]);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge aclk);
        checks += 4;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset m_tvalid: got %b required 0", m_tvalid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
        if (s_tready !== 3'b000) begin errors++; $display("FAIL reset s_tready: got %b required 000", s_tready); end
        if (m_tdata !== '0) begin errors++; $display("FAIL reset m_tdata: got %h required 0", m_tdata); end
        aresetn = 1'b1;
        repeat (5) @(negedge aclk);
        #1;
        clear_obs();
    endtask

    task automatic test_single_source();
        bit exp_busy[6] = '{0, 1, 1, 1, 0, 0};
        bit exp_mv[6]   = '{0, 0, 1, 1, 1, 0};
        bit exp_last[6] = '{0, 0, 0, 0, 1, 0};
        out_beat_t exp[$];
        m_tready = 1'b1;
        @(negedge aclk);
        push(0, "ABCDEFGHIJ", 10'h3FF, 1'b0, 0);
        push(0, "KLMNOPQRST", 10'h3FF, 1'b0, 0);
        push(0, "UVWXYZ0123", 10'h3FF, 1'b1, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge aclk);
            checks += 2;
            if (busy !== exp_busy[c]) begin errors++; $display("FAIL single busy cyc %0d: got %b required %b", c, busy, exp_busy[c]); end
            if (m_tvalid !== exp_mv[c]) begin errors++; $display("FAIL single m_tvalid cyc %0d: got %b required %b", c, m_tvalid, exp_mv[c]); end
            if (exp_mv[c]) begin
                checks += 2;
                if (m_tlast !== exp_last[c]) begin errors++; $display("FAIL single m_tlast cyc %0d: got %b required %b", c, m_tlast, exp_last[c]); end
                if (m_tid !== 2'd0) begin errors++; $display("FAIL single m_tid cyc %0d: got %0d required 0", c, m_tid); end
            end
        end
        exp.push_back(ob("ABCDEFGHIJ", 10'h3FF, 1'b0, 0));
        exp.push_back(ob("KLMNOPQRST", 10'h3FF, 1'b0, 0));
        exp.push_back(ob("UVWXYZ0123", 10'h3FF, 1'b1, 0));
        cmp_got(exp, "single");
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_rdy[10] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010,
                                    3'b010, 3'b000, 3'b100, 3'b100, 3'b000};
        out_beat_t exp[$];
        do_reset();
        @(negedge aclk);
        for (int s = 0; s < K; s++) begin
            push(s, mk(s, 0), 10'h3FF, 1'b0, 0);
            push(s, mk(s, 1), 10'h3FF, 1'b1, 0);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge aclk);
            checks++;
            if (s_tready !== exp_rdy[c]) begin
                errors++;
                $display("FAIL rr s_tready cyc %0d: got %b required %b", c, s_tready, exp_rdy[c]);
            end
        end
        repeat (3) @(negedge aclk);
        for (int s = 0; s < K; s++) begin
            exp.push_back(ob(mk(s, 0), 10'h3FF, 1'b0, s));
            exp.push_back(ob(mk(s, 1), 10'h3FF, 1'b1, s));
        end
        cmp_got(exp, "rr");
    endtask

    task automatic test_absorb();
        out_beat_t exp[$];
        clear_obs();
        @(negedge aclk);
        push(0, mk(0, 4), 10'h3FF, 1'b0, 0);
        push(0, mk(0, 5), 10'h000, 1'b0, 0);
        push(0, mk(0, 6), 10'h3FF, 1'b0, 0);
        push(0, 80'hBEEF, 10'h000, 1'b1, 0);
        for (int c = 0; c < 40 && acc_cnt[0] < 4; c++) begin
            @(negedge aclk);
            #1;
        end
        repeat (3) @(negedge aclk);
        checks++;
        if (acc_cnt[0] !== 4) begin errors++; $display("FAIL absorb accepted: got %0d required 4", acc_cnt[0]); end
        exp.push_back(ob(mk(0, 4), 10'h3FF, 1'b0, 0));
        exp.push_back(ob(mk(0, 6), 10'h3FF, 1'b0, 0));
        exp.push_back(ob(80'hBEEF, 10'h000, 1'b1, 0));
        cmp_got(exp, "absorb");
    endtask

    task automatic test_backpressure();
        out_beat_t exp[$];
        clear_obs();
        @(negedge aclk);
        for (int b = 0; b < 6; b++) push(1, mk(1, b), 10'h3FF, b == 5, 0);
        wait_got(2, "bp_start");
        @(posedge aclk);
        #1;
        m_tready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            checks += 4;
            if (m_tvalid !== 1'b1) begin errors++; $display("FAIL bp m_tvalid cyc %0d: got %b required 1", c, m_tvalid); end
            if (m_tdata !== mk(1, 2)) begin errors++; $display("FAIL bp m_tdata cyc %0d: got %h required %h", c, m_tdata, mk(1, 2)); end
            if (m_tkeep !== 10'h3FF) begin errors++; $display("FAIL bp m_tkeep cyc %0d: got %h required 3ff", c, m_tkeep); end
            if (s_tready !== 3'b000) begin errors++; $display("FAIL bp s_tready cyc %0d: got %b required 000", c, s_tready); end
        end
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        wait_got(6, "bp_end");
        repeat (2) @(negedge aclk);
        for (int b = 0; b < 6; b++) exp.push_back(ob(mk(1, b), 10'h3FF, b == 5, 1));
        cmp_got(exp, "bp");
    endtask

    task automatic test_valid_drop();
        out_beat_t exp[$];
        int drops;
        drops = 0;
        do_reset();
        @(negedge aclk);
        push(1, mk(1, 8), 10'h3FF, 1'b0, 0);
        push(1, mk(1, 9), 10'h3FF, 1'b0, 0);
        push(1, mk(1, 10), 10'h3FF, 1'b0, 3);
        push(1, mk(1, 11), 10'h3FF, 1'b1, 0);
        push(2, mk(2, 8), 10'h3FF, 1'b0, 0);
        push(2, mk(2, 9), 10'h3FF, 1'b1, 0);
        for (int c = 0; c < 80 && acc_cnt[1] < 4; c++) begin
            @(negedge aclk);
            #1;
            checks++;
            if (s_tready[2] !== 1'b0) begin errors++; $display("FAIL drop s_tready[2] cyc %0d: got %b required 0", c, s_tready[2]); end
            if (busy && !s_tvalid[1] && s_tvalid[2]) drops++;
        end
        checks++;
        if (drops !== 3) begin errors++; $display("FAIL drop gap cycles: got %0d required 3", drops); end
        wait_got(6, "drop_end");
        repeat (2) @(negedge aclk);
        for (int b = 8; b < 12; b++) exp.push_back(ob(mk(1, b), 10'h3FF, b == 11, 1));
        exp.push_back(ob(mk(2, 8), 10'h3FF, 1'b0, 2));
        exp.push_back(ob(mk(2, 9), 10'h3FF, 1'b1, 2));
        cmp_got(exp, "drop");
    endtask

    task automatic test_async_reset();
        out_beat_t exp[$];
        clear_obs();
        @(negedge aclk);
        push(0, mk(0, 12), 10'h3FF, 1'b1, 0);
        wait_got(1, "ar_single");
        repeat (2) @(negedge aclk);
        #1;
        clear_obs();
        for (int b = 0; b < 4; b++) push(1, mk(1, 12 + b), 10'h3FF, b == 3, 0);
        wait_got(1, "ar_mid");
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ar busy before reset: got %b required 1", busy); end
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        checks += 3;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL ar m_tvalid: got %b required 0", m_tvalid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ar busy: got %b required 0", busy); end
        if (s_tready !== 3'b000) begin errors++; $display("FAIL ar s_tready: got %b required 000", s_tready); end
        pend.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        repeat (5) @(negedge aclk);
        #1;
        clear_obs();
        push(2, mk(2, 13), 10'h3FF, 1'b1, 0);
        push(0, mk(0, 13), 10'h3FF, 1'b1, 0);
        wait_got(2, "ar_restart");
        repeat (2) @(negedge aclk);
        exp.push_back(ob(mk(0, 13), 10'h3FF, 1'b1, 0));
        exp.push_back(ob(mk(2, 13), 10'h3FF, 1'b1, 2));
        cmp_got(exp, "ar_restart");
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_absorb();
        test_backpressure();
        test_valid_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gearbox_stream_arbiter.md
Name: gearbox_stream_arbiter

Overview:
- Packet-level round-robin arbiter that shares one gearbox_packing instance between K AXI-Stream sources.
- Each source delivers n-byte beats with per-byte tkeep and packet tlast.
- The arbiter locks the grant for a whole packet, absorbs empty non-last beats, and drives the gearbox input through a registered output stage.
- It sits directly upstream of gearbox_packing (m_* connects to in_*), with m_tid carried alongside for downstream routing.

Parameters:
- K, 3, number of requesting sources (2..8)
- n, 10, bytes per beat (matches gearbox_packing n)
- NB, n*8, data width in bits (derived, not overridable)
- IDW, $clog2(K), width of m_tid

Ports:
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  reset, asynchronous assert, active-low
- s_tdata  in  K*NB  source data, source i at [i*NB +: NB]
- s_tkeep  in  K*n  source byte enables, source i at [i*n +: n]
- s_tlast  in  K  end-of-packet per source
- s_tvalid  in  K  valid per source
- s_tready  out  K  ready per source
- m_tdata  out  NB  data to gearbox in_tdata
- m_tkeep  out  n  keep to gearbox in_tkeep
- m_tlast  out  1  end of packet
- m_tid  out  IDW  index of the source that produced the beat
- m_tvalid  out  1  valid to gearbox in_tvalid
- m_tready  in  1  ready from gearbox in_tready
- busy  out  1  high while a packet is granted (state BURST)

Behaviour:
- Reset (async, aresetn=0): state=IDLE, rr_ptr=0, grant=0, m_tvalid=0, m_tdata/m_tkeep/m_tlast/m_tid=0, s_tready=0, busy=0. Deassertion is taken synchronously; the first arbitration happens no earlier than the 2nd rising edge after release.
- FSM states: IDLE, BURST.
  - IDLE: if any s_tvalid is set, grant = the first i in rotating order rr_ptr, rr_ptr+1, ... (mod K) with s_tvalid[i]=1. Register grant and go to BURST. s_tready stays all-zero in IDLE, so there is a 1-cycle bubble per packet.
  - BURST: only s_tready[grant] may be high: s_tready[grant] = !m_tvalid || m_tready. All other s_tready bits are 0.
  - Accepting a beat with s_tlast=1 returns the FSM to IDLE and sets rr_ptr <= (grant+1) mod K.
- Output stage: one-entry register.
  - On an accepted beat whose keep is non-zero or whose last is 1: load m_tdata, m_tkeep, m_tlast, m_tid=grant, and set m_tvalid=1. Latency from s-handshake to m_tvalid is 1 cycle.
  - When m_tvalid && m_tready and no new load occurs, clear m_tvalid.
  - Load and drain in the same cycle are legal, giving full throughput of 1 beat/cycle inside a packet.
- Absorption: a beat with tkeep=0 and tlast=0 is handshaken (consumed) but not loaded.
- A beat with tkeep=0 and tlast=1 is forwarded unchanged, so the gearbox sees the packet end.
- m_* outputs hold stable while m_tvalid && !m_tready (AXI rule).
- Source tvalid drop mid-packet: the FSM stays in BURST and waits. The grant is never revoked before tlast.
- Sources that request while another packet is granted wait. Round-robin guarantees each waiting source is served within K packets.
- busy = (state==BURST).
- A single-beat packet (tlast on the first beat) occupies BURST for exactly one accepted cycle.
- If aresetn asserts mid-packet, all state clears and any partially forwarded packet is lost. Resetting the gearbox together with this block is the system's responsibility.

Decomposition:
- gearbox_pkg holds:
  - localparam N_BYTES=10 and NB=N_BYTES*8
  - typedef beat_t (struct: data[NB], keep[N_BYTES], last)
  - typedef enum arb_state_t {IDLE, BURST}
- One natural sub-module: axis_out_stage, the one-entry registered valid/ready slice carrying beat_t plus tid. Arbitration and FSM stay in the top.

Test Plan:
- Single source 0 sends 3 beats "ABCDEFGHIJ" keep 10'h3FF, last on beat 3, m_tready=1 -> m_tvalid 1 cycle after each accept, m_tid=0, m_tlast only on beat 3, busy falls after the 3rd accept.
- Sources 0, 1 and 2 each hold a 2-beat packet valid from the same cycle, rr_ptr=0 -> grant order 0,1,2 with a 1-cycle bubble between packets, and the packets are not interleaved on m_*.
- In a packet, a mid beat keep=10'b0000000000 with last=0 -> consumed (s_tready pulses) but not on m_*; a final beat keep=0 with last=1 -> forwarded with m_tkeep=0 and m_tlast=1.
- m_tready low for 4 cycles mid-packet -> m_tdata/m_tkeep held constant, s_tready[grant]=0, no beat lost or duplicated; the scoreboard byte queue matches the gearbox output.
- Source 1 drops tvalid for 3 cycles mid-packet while source 2 is valid -> the grant stays on 1; source 2 is granted only after source 1's tlast.
- aresetn pulled low asynchronously mid-packet -> m_tvalid=0, busy=0 and s_tready=0 immediately (without waiting for a clock edge); after release, arbitration restarts from rr_ptr=0.
